// File: rtl/mult_unit.sv
// Iterative shift-add 32x32 multiplier for MULT/MULTU: one add-with-carry per cycle,
// sign handled by multiplying magnitudes and negating the 64-bit product at the end.
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     sum33;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  assign sum33 = {1'b0, acc_q} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
  assign prod  = {acc_q, mplr_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          mplr_d  = b_mag;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Carry-out of the add shifts into the top of acc; the low bit shifts into mplr.
        {acc_d, mplr_d} = {sum33, mplr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (neg_q) begin
          {hi_d, lo_d} = ~prod + (2*WIDTH)'(1);
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q == S_BUSY) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule
